// File: rtl/switch_pkg.sv
// switch_pkg: shared types and defaults for the switch debouncer.
//   swState_t             per-channel debounce FSM state
//   DEFAULT_NUM_SW        default number of switch channels
//   DEFAULT_STABLE_CYCLES default settle time in clk cycles (1 ms at 100 MHz)
package switch_pkg;

    typedef enum logic {
        SW_STABLE,
        SW_PENDING
    } swState_t;

    localparam int DEFAULT_NUM_SW        = 8;
    localparam int DEFAULT_STABLE_CYCLES = 100000;

endpackage

// File: rtl/switch_debounce_channel.sv
// switch_debounce_channel: one switch channel with synchronizer, debounce FSM and edge pulses.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   swRaw      raw bouncing switch level
//   swStable   debounced level
//   swChanged  one-cycle pulse when swStable toggles
//   swRise     one-cycle pulse on a 0->1 acceptance
//   swFall     one-cycle pulse on a 1->0 acceptance
module switch_debounce_channel
    import switch_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic swRaw,
    output logic swStable,
    output logic swChanged,
    output logic swRise,
    output logic swFall
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [1:0]    syncReg;
    logic          s;
    swState_t      state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic          accept;
    logic          differs;
    logic          lastCount;

    assign s         = syncReg[1];
    assign differs   = s != swStable;
    // The counter is 0 while STABLE, so with STABLE_CYCLES==1 this also
    // makes the first differing cycle an immediate acceptance.
    assign lastCount = cnt == CW'(STABLE_CYCLES - 1);

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        accept    = 1'b0;
        case (state)
            SW_STABLE: begin
                if (differs && lastCount) begin
                    accept  = 1'b1;
                    cntNext = '0;
                end else if (differs) begin
                    stateNext = SW_PENDING;
                    cntNext   = CW'(1);
                end else begin
                    cntNext = '0;
                end
            end
            default: begin
                if (!differs) begin
                    stateNext = SW_STABLE;
                    cntNext   = '0;
                end else if (lastCount) begin
                    stateNext = SW_STABLE;
                    cntNext   = '0;
                    accept    = 1'b1;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncReg   <= '0;
            state     <= SW_STABLE;
            cnt       <= '0;
            swStable  <= 1'b0;
            swChanged <= 1'b0;
            swRise    <= 1'b0;
            swFall    <= 1'b0;
        end else begin
            syncReg   <= {syncReg[0], swRaw};
            state     <= stateNext;
            cnt       <= cntNext;
            // An acceptance always flips the level, since it requires s != swStable.
            swStable  <= swStable ^ accept;
            swChanged <= accept;
            swRise    <= accept & s;
            swFall    <= accept & ~s;
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: NUM_SW independent debounced switch channels.
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   sw_raw      raw bouncing switch levels
//   sw_stable   debounced levels
//   sw_changed  one-cycle toggle pulses
//   sw_rise     one-cycle 0->1 pulses
//   sw_fall     one-cycle 1->0 pulses
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int NUM_SW        = DEFAULT_NUM_SW,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_stable,
    output logic [NUM_SW-1:0] sw_changed,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall
);

    for (genvar g = 0; g < NUM_SW; g++) begin : genChannel
        switch_debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) uChannel (
            .clk      (clk),
            .rst_n    (rst_n),
            .swRaw    (sw_raw[g]),
            .swStable (sw_stable[g]),
            .swChanged(sw_changed[g]),
            .swRise   (sw_rise[g]),
            .swFall   (sw_fall[g])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed and random checks of switch_debouncer against a windowed reference model.
module tb_switch_debouncer;

    localparam int NSW = 4;
    localparam int SC  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NSW-1:0] sw_raw = '0;
    logic [NSW-1:0] sw_stable, sw_changed, sw_rise, sw_fall;

    int nTests = 0;
    int nFail  = 0;

    // Reference model: raw is seen by the debouncer two edges late; a level
    // is accepted at the edge where the last SC synchronized samples all
    // differ from the current stable level.
    bit [NSW-1:0] m1, m2, stab, chg, ris, fal;
    bit [NSW-1:0] hist[SC];

    always #5 clk = ~clk;

    switch_debouncer #(
        .NUM_SW(NSW),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_raw    (sw_raw),
        .sw_stable (sw_stable),
        .sw_changed(sw_changed),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall)
    );

    task automatic check(input string tag, input logic [NSW-1:0] obs, input logic [NSW-1:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m1 = '0; m2 = '0; stab = '0; chg = '0; ris = '0; fal = '0;
        for (int j = 0; j < SC; j++) hist[j] = '0;
    endtask

    task automatic modelEdge();
        bit [NSW-1:0] acc;
        if (!rst_n) begin
            modelReset();
        end else begin
            for (int j = SC - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = m2;
            for (int i = 0; i < NSW; i++) begin
                acc[i] = 1'b1;
                for (int j = 0; j < SC; j++)
                    if (hist[j][i] == stab[i]) acc[i] = 1'b0;
            end
            chg  = acc;
            ris  = acc & ~stab;
            fal  = acc & stab;
            stab = stab ^ acc;
            m2   = m1;
            m1   = sw_raw;
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            modelEdge();
            @(posedge clk);
            #1;
            check("stable", sw_stable, stab);
            check("changed", sw_changed, chg);
            check("rise", sw_rise, ris);
            check("fall", sw_fall, fal);
            check("riseFallExclusive", sw_rise & sw_fall, '0);
        end
    endtask

    initial begin
        modelReset();
        // Reset, then idle with all switches low.
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("idleStable", sw_stable, 4'b0000);
        check("idleChanged", sw_changed, 4'b0000);

        // Channel 0 rises; accepted at edge SC+2.
        sw_raw[0] = 1'b1;
        tick(5);
        check("ch0BeforeAccept", sw_stable, 4'b0000);
        tick(1);
        check("ch0Stable", sw_stable, 4'b0001);
        check("ch0Changed", sw_changed, 4'b0001);
        check("ch0Rise", sw_rise, 4'b0001);
        tick(1);
        check("ch0PulseEnd", sw_changed, 4'b0000);

        // Channel 1 glitches shorter than SC synchronized cycles.
        repeat (5) begin
            sw_raw[1] = 1'b1;
            tick(3);
            sw_raw[1] = 1'b0;
            tick(4);
        end
        tick(4);
        check("glitchStable", sw_stable, 4'b0001);

        // Release channel 0 and settle.
        sw_raw[0] = 1'b0;
        tick(8);
        check("ch0Released", sw_stable, 4'b0000);

        // Channels 2 and 3 rise together, then channel 2 falls.
        sw_raw[3:2] = 2'b11;
        tick(6);
        check("dualRise", sw_rise, 4'b1100);
        check("dualStable", sw_stable, 4'b1100);
        tick(3);
        sw_raw[2] = 1'b0;
        tick(5);
        check("ch2FallEarly", sw_fall, 4'b0000);
        tick(1);
        check("ch2Fall", sw_fall, 4'b0100);
        check("ch2Stable", sw_stable, 4'b1000);

        // Reset while channel 0 is pending at count 2.
        sw_raw[3] = 1'b0;
        tick(8);
        sw_raw[0] = 1'b1;
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        check("asyncRstStable", sw_stable, 4'b0000);
        check("asyncRstChanged", sw_changed, 4'b0000);
        check("asyncRstRise", sw_rise, 4'b0000);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("postRstBefore", sw_stable, 4'b0000);
        tick(1);
        check("postRstRise", sw_rise, 4'b0001);
        check("postRstStable", sw_stable, 4'b0001);

        // Random bouncing with occasional resets.
        repeat (400) begin
            sw_raw = sw_raw ^ NSW'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
            tick($urandom_range(1, 8));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
